parity_frame_gen: RTL and testbench

Streaming parity generator. Accumulates parity over a multi-word frame of DATA_W-bit words and appends one parity beat after the last data word. The even/odd mode is selectable per frame. It sits between a data producer and a serialiser/link layer, using valid/ready handshakes on both sides, and replaces the single-word combinational parity generator.

---
 rtl/parity_frame_gen.sv | 202 ++++++++++++++++++++
 tb/tb_parity_frame_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_gen.sv
// Streaming frame parity generator: forwards data words and appends one parity beat per frame.
// Define PARITY_CHECK_EN to add the par_in / par_err / err_cnt checking ports.
module parity_frame_gen #(
   parameter int  DATA_W    = 8,
   parameter int  MAX_WORDS = 16,
   localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              even_odd,
`ifdef PARITY_CHECK_EN
   input  logic              par_in,
   output logic              par_err,
   output logic [7:0]        err_cnt,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_is_par,
   output logic              out_last,
   output logic [CNT_W-1:0]  frame_words,
   output logic              frame_trunc
);

   typedef enum logic [0:0] {ACCUM = 1'b0, EMIT = 1'b1} state_t;

   state_t             state_q, state_d;
   logic               acc_q, acc_d;
   logic               mode_q, mode_d;
   logic               trunc_q, trunc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic               out_is_par_q, out_is_par_d;
   logic               out_last_q, out_last_d;
   logic [CNT_W-1:0]   frame_words_q, frame_words_d;
   logic               frame_trunc_q, frame_trunc_d;
`ifdef PARITY_CHECK_EN
   logic               par_exp_q, par_exp_d;
   logic               par_err_q, par_err_d;
   logic [7:0]         err_cnt_q, err_cnt_d;
`endif

   logic               slot_free;
   logic               in_fire;
   logic [CNT_W-1:0]   cnt_inc;
   logic               par_bit;

   assign slot_free = !out_valid_q || out_ready;
   // rst_n is folded in so the producer sees in_ready low for the whole reset.
   assign in_ready  = rst_n && (state_q == ACCUM) && slot_free;
   assign in_fire   = in_valid && in_ready;
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign par_bit   = mode_q ? acc_q : ~acc_q;

   // Next-state, accumulator and output-register update.
   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      mode_d        = mode_q;
      trunc_d       = trunc_q;
      cnt_d         = cnt_q;
      out_valid_d   = out_valid_q && !out_ready;
      out_data_d    = out_data_q;
      out_is_par_d  = out_is_par_q;
      out_last_d    = out_last_q;
      frame_words_d = frame_words_q;
      frame_trunc_d = frame_trunc_q;
`ifdef PARITY_CHECK_EN
      par_exp_d     = par_exp_q;
      par_err_d     = par_err_q;
`endif
      case (state_q)
         ACCUM: begin
            if (in_fire) begin
               out_valid_d   = 1'b1;
               out_data_d    = in_data;
               out_is_par_d  = 1'b0;
               out_last_d    = 1'b0;
               frame_words_d = {CNT_W{1'b0}};
               frame_trunc_d = 1'b0;
               acc_d         = acc_q ^ (^in_data);
               cnt_d         = cnt_inc;
`ifdef PARITY_CHECK_EN
               par_err_d     = 1'b0;
               if (in_last) begin
                  par_exp_d = par_in;
               end else begin
                  par_exp_d = par_exp_q;
               end
`endif
               // Mode is frozen by the first word; later even_odd values are ignored.
               if (cnt_q == {CNT_W{1'b0}}) begin
                  mode_d = even_odd;
               end else begin
                  mode_d = mode_q;
               end
               if (in_last || (cnt_inc == CNT_W'(MAX_WORDS))) begin
                  state_d = EMIT;
                  trunc_d = !in_last;
               end else begin
                  state_d = ACCUM;
                  trunc_d = trunc_q;
               end
            end else begin
               state_d = ACCUM;
            end
         end
         EMIT: begin
            if (slot_free) begin
               out_valid_d    = 1'b1;
               out_data_d     = {DATA_W{1'b0}};
               out_data_d[0]  = par_bit;
               out_is_par_d   = 1'b1;
               out_last_d     = 1'b1;
               frame_words_d  = cnt_q;
               frame_trunc_d  = trunc_q;
`ifdef PARITY_CHECK_EN
               par_err_d      = !trunc_q && (par_bit != par_exp_q);
               par_exp_d      = 1'b0;
`endif
               acc_d          = 1'b0;
               cnt_d          = {CNT_W{1'b0}};
               trunc_d        = 1'b0;
               state_d        = ACCUM;
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

`ifdef PARITY_CHECK_EN
   // Saturating count of parity beats delivered with a mismatch.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (out_valid_q && out_ready && out_is_par_q && par_err_q && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end
`endif

   // State and output registers; reset discards any partial frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ACCUM;
         acc_q         <= 1'b0;
         mode_q        <= 1'b1;
         trunc_q       <= 1'b0;
         cnt_q         <= {CNT_W{1'b0}};
         out_valid_q   <= 1'b0;
         out_data_q    <= {DATA_W{1'b0}};
         out_is_par_q  <= 1'b0;
         out_last_q    <= 1'b0;
         frame_words_q <= {CNT_W{1'b0}};
         frame_trunc_q <= 1'b0;
`ifdef PARITY_CHECK_EN
         par_exp_q     <= 1'b0;
         par_err_q     <= 1'b0;
         err_cnt_q     <= 8'd0;
`endif
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         mode_q        <= mode_d;
         trunc_q       <= trunc_d;
         cnt_q         <= cnt_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_is_par_q  <= out_is_par_d;
         out_last_q    <= out_last_d;
         frame_words_q <= frame_words_d;
         frame_trunc_q <= frame_trunc_d;
`ifdef PARITY_CHECK_EN
         par_exp_q     <= par_exp_d;
         par_err_q     <= par_err_d;
         err_cnt_q     <= err_cnt_d;
`endif
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_is_par  = out_is_par_q;
   assign out_last    = out_last_q;
   assign frame_words = frame_words_q;
   assign frame_trunc = frame_trunc_q;
`ifdef PARITY_CHECK_EN
   assign par_err     = par_err_q;
   assign err_cnt     = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_gen.sv
// Scoreboard bench for parity_frame_gen (DATA_W=8, MAX_WORDS=4) with directed frames.
`timescale 1ns/1ps
module tb_parity_frame_gen;
   localparam int DW = 8;
   localparam int MW = 4;
   localparam int CW = $clog2(MW + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = 8'h00;
   logic          in_last = 1'b0;
   logic          even_odd = 1'b1;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_is_par;
   logic          out_last;
   logic [CW-1:0] frame_words;
   logic          frame_trunc;
`ifdef PARITY_CHECK_EN
   logic          par_in = 1'b0;
   logic          par_err;
   logic [7:0]    err_cnt;
`endif

   typedef struct packed {
      logic [DW-1:0] data;
      logic          is_par;
      logic          last;
      logic [CW-1:0] words;
      logic          trunc;
      logic          perr;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    failures = 0;

   parity_frame_gen #(.DATA_W(DW), .MAX_WORDS(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .even_odd(even_odd),
`ifdef PARITY_CHECK_EN
      .par_in(par_in), .par_err(par_err), .err_cnt(err_cnt),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_is_par(out_is_par), .out_last(out_last),
      .frame_words(frame_words), .frame_trunc(frame_trunc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic send(input logic [DW-1:0] d, input logic last, input logic eo, input logic pin);
      bit done = 1'b0;
      exp_q.push_back('{data: d, is_par: 1'b0, last: 1'b0, words: {CW{1'b0}}, trunc: 1'b0, perr: 1'b0});
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      even_odd = eo;
`ifdef PARITY_CHECK_EN
      par_in   = pin;
`endif
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h pin=%0b", d, pin);
      end
      in_valid = 1'b0;
   endtask

   task automatic expect_par(input logic par, input logic [CW-1:0] words, input logic trunc, input logic perr);
      beat_t b;
      b.data   = {{(DW-1){1'b0}}, par};
      b.is_par = 1'b1;
      b.last   = 1'b1;
      b.words  = words;
      b.trunc  = trunc;
      b.perr   = perr;
      exp_q.push_back(b);
   endtask

   task automatic monitor();
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat actual=%0h required=none", out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(e.data));
               check("out_is_par", 32'(out_is_par), 32'(e.is_par));
               check("out_last", 32'(out_last), 32'(e.last));
               check("frame_words", 32'(frame_words), 32'(e.words));
               check("frame_trunc", 32'(frame_trunc), 32'(e.trunc));
`ifdef PARITY_CHECK_EN
               check("par_err", 32'(par_err), 32'(e.perr));
`endif
            end
         end
      end
   endtask

   task automatic drain();
      int c = 0;
      while (exp_q.size() != 0 && c < 300) begin
         @(negedge clk);
         c++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      fork
         monitor();
      join_none

      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_is_par", 32'(out_is_par), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_frame_words", 32'(frame_words), 32'd0);
      check("rst_frame_trunc", 32'(frame_trunc), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Even frame {01,03}: parity of 1+2 set bits -> 1.
      send(8'h01, 1'b0, 1'b1, 1'b0);
      send(8'h03, 1'b1, 1'b1, 1'b1);
      expect_par(1'b1, 3'd2, 1'b0, 1'b0);
      // Odd mode latched on word 1; even_odd=1 on word 2 is ignored.
      send(8'h01, 1'b0, 1'b0, 1'b0);
      send(8'h03, 1'b1, 1'b1, 1'b0);
      expect_par(1'b0, 3'd2, 1'b0, 1'b0);
      // Forced end after 4 words (bits 1,1,2,1 -> odd total -> parity 1), then single-word frame.
      send(8'h10, 1'b0, 1'b1, 1'b0);
      send(8'h20, 1'b0, 1'b1, 1'b0);
      send(8'h30, 1'b0, 1'b1, 1'b0);
      send(8'h40, 1'b0, 1'b1, 1'b0);
      expect_par(1'b1, 3'd4, 1'b1, 1'b0);
      send(8'h07, 1'b1, 1'b1, 1'b1);
      expect_par(1'b1, 3'd1, 1'b0, 1'b0);
      drain();

      // Backpressure: one word buffered, input stalls, output holds.
      send(8'hA5, 1'b0, 1'b1, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h5A;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_out_data", 32'(out_data), 32'hA5);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(8'h5A, 1'b0, 1'b1, 1'b0);
      send(8'h81, 1'b1, 1'b1, 1'b0);
      expect_par(1'b0, 3'd3, 1'b0, 1'b0);
      drain();

      // Async reset after 2 words of a 3-word frame.
      send(8'h11, 1'b0, 1'b1, 1'b0);
      send(8'h22, 1'b0, 1'b1, 1'b0);
      out_ready = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      send(8'hFF, 1'b1, 1'b1, 1'b0);
      expect_par(1'b0, 3'd1, 1'b0, 1'b0);
      drain();

`ifdef PARITY_CHECK_EN
      check("err_cnt_start", 32'(err_cnt), 32'd0);
      send(8'h07, 1'b1, 1'b1, 1'b0);
      expect_par(1'b1, 3'd1, 1'b0, 1'b1);
      drain();
      check("err_cnt_one", 32'(err_cnt), 32'd1);
      for (int i = 0; i < 299; i++) begin
         send(8'h07, 1'b1, 1'b1, 1'b0);
         expect_par(1'b1, 3'd1, 1'b0, 1'b1);
      end
      drain();
      check("err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
